led_blink_ctrl: RTL and testbench

//  Parametrised multi-channel LED controller; generalises the single fixed-rate 1 Hz blinker.
//  A shared prescaler produces a timebase tick. Each channel runs in one of four runtime-selectable modes:
//  OFF, ON, BLINK (per-channel half-period) or PULSE (one-shot).

---
 rtl/led_ctrl_pkg.sv | 16 +
 rtl/led_channel.sv | 100 ++++++++++
 rtl/led_blink_ctrl.sv | 74 +++++++
 tb/tb_led_blink_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared LED-controller definitions: channel mode encodings and the channel-index width helper.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        LED_MODE_OFF   = 2'b00,
        LED_MODE_ON    = 2'b01,
        LED_MODE_BLINK = 2'b10,
        LED_MODE_PULSE = 2'b11
    } led_mode_e;

    // A single channel still needs a 1-bit select port.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: mode/half-period/counter state plus registered led and pulse_done outputs.
module led_channel
    import led_ctrl_pkg::*;
#(
    parameter int              CNT_W    = 16,
    parameter led_mode_e       RST_MODE = LED_MODE_OFF,
    parameter logic [CNT_W-1:0] RST_HP  = 1,
    parameter logic            RST_LED  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             load,
    input  led_mode_e        load_mode,
    input  logic [CNT_W-1:0] load_hp,
    input  logic             sync,
    output logic             led,
    output logic             pulse_done
);

    led_mode_e        mode_q, mode_d;
    logic [CNT_W-1:0] hp_q, hp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             led_q, led_d;
    logic             pd_q, pd_d;
    logic [CNT_W-1:0] hp_last;

    // A stored half-period of 0 behaves as 1, so its last count is also 0.
    assign hp_last = (hp_q == '0) ? '0 : hp_q - CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q <= RST_MODE;
            hp_q   <= RST_HP;
            cnt_q  <= '0;
            led_q  <= RST_LED;
            pd_q   <= 1'b0;
        end else begin
            mode_q <= mode_d;
            hp_q   <= hp_d;
            cnt_q  <= cnt_d;
            led_q  <= led_d;
            pd_q   <= pd_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        hp_d   = hp_q;
        cnt_d  = cnt_q;
        led_d  = led_q;
        pd_d   = 1'b0;
        if (load) begin
            mode_d = load_mode;
            hp_d   = load_hp;
            cnt_d  = '0;
            led_d  = (load_mode != LED_MODE_OFF);
        end else if (sync && mode_q == LED_MODE_BLINK) begin
            cnt_d = '0;
            led_d = 1'b1;
        end else if (tick) begin
            unique case (mode_q)
                LED_MODE_OFF: begin
                    cnt_d = '0;
                    led_d = 1'b0;
                end
                LED_MODE_ON: begin
                    cnt_d = '0;
                    led_d = 1'b1;
                end
                LED_MODE_BLINK: begin
                    if (cnt_q == hp_last) begin
                        cnt_d = '0;
                        led_d = ~led_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                LED_MODE_PULSE: begin
                    if (cnt_q == hp_last) begin
                        cnt_d  = '0;
                        led_d  = 1'b0;
                        mode_d = LED_MODE_OFF;
                        pd_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        led_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        led        = led_q;
        pulse_done = pd_q;
    end

endmodule

// File: rtl/led_blink_ctrl.sv
// Multi-channel LED controller top: shared prescaler tick, config write decode and sync fan-out.
module led_blink_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int   NUM_CH      = 4,
    parameter int   CNT_W       = 16,
    parameter int   PRESCALE    = 24000,
    parameter int   HB_HALF_PER = 500,
    localparam int  CH_W        = ch_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [CNT_W-1:0]  cfg_half_per,
    input  logic              sync,
    output logic              tick,
    output logic [NUM_CH-1:0] led,
    output logic [NUM_CH-1:0] pulse_done
);

    localparam int PW = $clog2(PRESCALE);

    logic [PW-1:0]     presc_q, presc_d;
    logic              tick_q, tick_d;
    logic [NUM_CH-1:0] load;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    // sync restarts the timebase and suppresses the tick that would have fired.
    always_comb begin
        tick_d  = 1'b0;
        presc_d = presc_q + PW'(1);
        if (sync) begin
            presc_d = '0;
        end else if (presc_q == PW'(PRESCALE - 1)) begin
            presc_d = '0;
            tick_d  = 1'b1;
        end
    end

    assign tick = tick_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign load[i] = cfg_we && (cfg_ch == CH_W'(i));

        led_channel #(
            .CNT_W    (CNT_W),
            .RST_MODE ((i == 0) ? LED_MODE_BLINK : LED_MODE_OFF),
            .RST_HP   ((i == 0) ? CNT_W'(HB_HALF_PER) : CNT_W'(1)),
            .RST_LED  ((i == 0) ? 1'b1 : 1'b0)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .tick       (tick_q),
            .load       (load[i]),
            .load_mode  (led_mode_e'(cfg_mode)),
            .load_hp    (cfg_half_per),
            .sync       (sync),
            .led        (led[i]),
            .pulse_done (pulse_done[i])
        );
    end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Directed and randomized bench for led_blink_ctrl, checked against a tick-count reference model.
module tb_led_blink_ctrl;

    localparam int P   = 4;
    localparam int HB  = 3;
    localparam int OFF = 0, ON = 1, BLINK = 2, PULSE = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_ch = '0;
    logic [1:0] cfg_mode = '0;
    logic [7:0] cfg_half_per = '0;
    logic       sync = 1'b0;
    logic       tick, tick3;
    logic [3:0] led, pulse_done;
    logic [2:0] led3, pulse_done3;

    int checks = 0;
    int errors = 0;

    // Reference state: per instance (0: 4 channels, 1: 3 channels) and channel.
    int m_presc = 0;
    bit m_tick = 0;
    int m_mode [2][4];
    int m_hp   [2][4];
    int m_k    [2][4];
    bit m_led  [2][4];
    bit m_pd   [2][4];

    always #5 clk = ~clk;

    led_blink_ctrl #(.NUM_CH(4), .CNT_W(8), .PRESCALE(P), .HB_HALF_PER(HB)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
        .cfg_half_per(cfg_half_per), .sync(sync), .tick(tick), .led(led), .pulse_done(pulse_done)
    );

    led_blink_ctrl #(.NUM_CH(3), .CNT_W(8), .PRESCALE(P), .HB_HALF_PER(HB)) dut3 (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
        .cfg_half_per(cfg_half_per), .sync(sync), .tick(tick3), .led(led3), .pulse_done(pulse_done3)
    );

    // BLINK led = 1 xor parity of completed half-periods since the phase start.
    task automatic model_step();
        bit tk;
        tk = m_tick;
        if (!rst_n) begin
            m_presc = 0;
            m_tick  = 0;
            for (int n = 0; n < 2; n++)
                for (int c = 0; c < 4; c++) begin
                    m_mode[n][c] = (c == 0) ? BLINK : OFF;
                    m_hp[n][c]   = (c == 0) ? HB : 1;
                    m_k[n][c]    = 0;
                    m_led[n][c]  = (c == 0);
                    m_pd[n][c]   = 0;
                end
        end else begin
            m_tick  = !sync && (m_presc == P - 1);
            m_presc = sync ? 0 : (m_presc + 1) % P;
            for (int n = 0; n < 2; n++)
                for (int c = 0; c < 4 - n; c++) begin
                    m_pd[n][c] = 0;
                    if (cfg_we && int'(cfg_ch) == c) begin
                        m_mode[n][c] = int'(cfg_mode);
                        m_hp[n][c]   = (cfg_half_per == 0) ? 1 : int'(cfg_half_per);
                        m_k[n][c]    = 0;
                        m_led[n][c]  = (cfg_mode != 2'd0);
                    end else if (sync && m_mode[n][c] == BLINK) begin
                        m_k[n][c]   = 0;
                        m_led[n][c] = 1;
                    end else if (tk) begin
                        case (m_mode[n][c])
                            OFF: m_led[n][c] = 0;
                            ON:  m_led[n][c] = 1;
                            BLINK: begin
                                m_k[n][c]++;
                                m_led[n][c] = 1'b1 ^ 1'((m_k[n][c] / m_hp[n][c]) % 2);
                            end
                            default: begin
                                m_k[n][c]++;
                                if (m_k[n][c] >= m_hp[n][c]) begin
                                    m_mode[n][c] = OFF;
                                    m_k[n][c]    = 0;
                                    m_led[n][c]  = 0;
                                    m_pd[n][c]   = 1;
                                end else begin
                                    m_led[n][c] = 1;
                                end
                            end
                        endcase
                    end
                end
        end
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: advance the model at the edge, compare all outputs just after it.
    task automatic cycle();
        logic [3:0] el4, ep4, el3, ep3;
        @(posedge clk);
        model_step();
        #1;
        el4 = '0; ep4 = '0; el3 = '0; ep3 = '0;
        for (int c = 0; c < 4; c++) begin
            el4[c] = m_led[0][c];
            ep4[c] = m_pd[0][c];
        end
        for (int c = 0; c < 3; c++) begin
            el3[c] = m_led[1][c];
            ep3[c] = m_pd[1][c];
        end
        check("tick", {3'b0, tick}, {3'b0, m_tick});
        check("tick_3ch", {3'b0, tick3}, {3'b0, m_tick});
        check("led", led, el4);
        check("pulse_done", pulse_done, ep4);
        check("led_3ch", {1'b0, led3}, el3);
        check("pulse_done_3ch", {1'b0, pulse_done3}, ep3);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic write(input int ch, input int mode, input int hp);
        cfg_we = 1'b1;
        cfg_ch = 2'(ch);
        cfg_mode = 2'(mode);
        cfg_half_per = 8'(hp);
        cycle();
        cfg_we = 1'b0;
    endtask

    initial begin
        int pd_cnt;
        int guard;
        for (int n = 0; n < 2; n++)
            for (int c = 0; c < 4; c++) begin
                m_mode[n][c] = OFF; m_hp[n][c] = 1; m_k[n][c] = 0; m_led[n][c] = 0; m_pd[n][c] = 0;
            end

        // Reset state
        rst_n = 1'b0;
        run(2);
        check("reset_led", led, 4'b0001);
        check("reset_pd", pulse_done, 4'b0000);
        rst_n = 1'b1;

        // 1: free-running heartbeat
        run(30);

        // 2: ch1 BLINK hp=2, ch2 ON, ch3 OFF
        write(1, BLINK, 2);
        write(2, ON, 7);
        check("ch2_on", {3'b0, led[2]}, 4'b0001);
        write(3, OFF, 1);
        run(20);

        // 3: ch3 one-shot pulse of 5 ticks
        write(3, PULSE, 5);
        check("ch3_pulse_start", {3'b0, led[3]}, 4'b0001);
        pd_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (pulse_done[3]) pd_cnt++;
        end
        check("pd3_count", 4'(pd_cnt), 4'd1);
        check("ch3_after_pulse", {3'b0, led[3]}, 4'b0000);

        // 4: hp=0 acts as 1; channel 3 absent in the 3-channel instance
        write(1, BLINK, 0);
        run(12);
        write(3, ON, 2);
        check("ch3_ignored_3ch", {1'b0, led3}, {1'b0, led[2:0]});
        run(4);

        // 5: sync two out-of-phase blinkers, plus a same-cycle write to ch2
        write(0, BLINK, 3);
        run(9);
        write(1, BLINK, 3);
        run(5);
        sync = 1'b1;
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_mode = 2'(PULSE); cfg_half_per = 8'd4;
        cycle();
        sync = 1'b0; cfg_we = 1'b0;
        check("sync_leds", {2'b0, led[1:0]}, 4'b0011);
        check("sync_notick", {3'b0, tick}, 4'b0000);
        run(30);

        // 6: write coinciding with a tick, then reset mid-pulse
        guard = 0;
        while (tick !== 1'b1 && guard < 10) begin
            cycle();
            guard++;
        end
        check("tick_seen", {3'b0, tick}, 4'b0001);
        write(0, BLINK, 3);
        check("write_over_tick", {3'b0, led[0]}, 4'b0001);
        run(8);
        write(3, PULSE, 5);
        run(6);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
        check("post_reset_led", led, 4'b0001);
        check("post_reset_pd", pulse_done, 4'b0000);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            cfg_we = ($urandom_range(0, 3) == 0);
            cfg_ch = 2'($urandom_range(0, 3));
            cfg_mode = 2'($urandom_range(0, 3));
            cfg_half_per = 8'($urandom_range(0, 4));
            sync = ($urandom_range(0, 19) == 0);
            rst_n = ($urandom_range(0, 199) != 0);
            cycle();
        end
        cfg_we = 1'b0; sync = 1'b0; rst_n = 1'b1;
        run(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
